burst_writer: RTL and testbench
===============================

Name: burst_writer

Overview:
Parametrised successor to the single-word bus writer. It waits a programmable gap, requests the shared bus, then drives a burst of BURST_LEN data words onto the tristated shared data bus, one word per granted cycle. It sits beside other writers on the arbiter-controlled bus. Compared with the single-word writer it adds:
- configurable data width
- multi-beat bursts with stall on busy
- a configurable increment step
- an enable input
- beat, last and burst-count status

Parameters:
DATA_W, 8, width of o_data and of the internal data register
COUNTER_MAX, 5, gap cycles spent in WAIT before requesting; must be >= 1
BURST_LEN, 4, beats per burst; must be >= 1
STEP, 1, increment applied to the data register per transferred beat
SEED, 0, data register value after reset

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_enable  in  1  allows new bursts to start; gap timer pauses while low
i_busy  in  1  arbiter busy; low while o_req is high means granted
o_req  out  1  registered bus request
o_data  out  DATA_W  data bus; driven only on a granted cycle, else all Z
o_valid  out  1  beat transferred this cycle (= grant)
o_last  out  1  final beat of burst this cycle
o_bursts  out  16  count of completed bursts, wraps at 2^16

Behaviour:
- grant = o_req && !i_busy (combinational).
- o_valid = grant.
- o_data = grant ? data_reg : Z.
- o_last = grant && (beat == BURST_LEN-1).
- Reset: state START, o_req 0, data_reg SEED, gap 0, beat 0, o_bursts 0. Reset mid-burst behaves the same: o_req low after the reset edge, partial burst discarded, no o_bursts increment.
- States: START, WAIT, REQ. Encoding must stay below the state count.
- START: gap <= 0, beat <= 0, o_req <= 0.
  - Go to WAIT if i_enable, else stay in START.
- WAIT:
  - If i_enable: gap <= gap+1.
  - When gap == COUNTER_MAX-1 with i_enable high: go to REQ and set o_req <= 1.
  - If !i_enable: gap holds and the state holds.
- REQ: o_req stays 1 regardless of i_enable or i_busy until the burst completes.
  - Each grant cycle: data_reg <= data_reg + STEP (mod 2^DATA_W), beat <= beat+1.
  - Busy cycle: stall; data_reg, beat and o_req all hold, and o_data is Z.
  - Grant with beat == BURST_LEN-1: o_req <= 0, o_bursts <= o_bursts+1, go to START.
- Never drop o_req while a requested burst is incomplete, absent reset.
- data_reg is not reloaded between bursts; the sequence continues across bursts and wraps.
- Timing, enable held high, reset released before edge 0:
  - edge 1: START to WAIT
  - edges 2..(COUNTER_MAX+1): WAIT
  - o_req high after edge COUNTER_MAX+1
- Minimum burst period = COUNTER_MAX + BURST_LEN + 1 cycles.
- BURST_LEN = 1 degenerates to the single-word writer behaviour.

Decomposition:
- Package burst_writer_pkg holds:
  - state enum (START, WAIT, REQ)
  - beat counter width localparam $clog2(BURST_LEN+1)
  - gap counter width localparam $clog2(COUNTER_MAX+1)
- One natural sub-module: gap_timer (enable-gated up-counter with clear and a terminal-count flag), instantiated once.
- The beat counter and data register stay inline.

Test Plan:
1. COUNTER_MAX=5, BURST_LEN=4, STEP=1, enable=1, busy=0 -> o_req rises after edge 6; o_data 0,1,2,3 on 4 consecutive cycles; o_last on the beat carrying 3; o_req low after edge 10; second burst 4..7; o_bursts=2 after edge 20.
2. Same config, busy=1 for 3 cycles at request, then busy pulses 1 cycle after beat 1 -> o_req held high throughout; o_data Z during busy; beats 0,1,(stall),2,3; no skipped or duplicated values.
3. DATA_W=4, STEP=3, SEED=14 -> beats 14,1,4,7 (wrap mod 16).
4. Enable dropped for 4 cycles mid-WAIT at gap=2 -> request delayed exactly 4 cycles. Enable dropped during REQ -> burst completes normally, then stays in START until enable returns.
5. Reset asserted after beat 2 of a burst -> o_req 0 and o_data Z on the next cycle; data restarts at SEED; o_bursts 0.
6. BURST_LEN=1, COUNTER_MAX=1 -> one word per 3-cycle period; o_last equals o_valid on every beat.

Source files
------------

// File: rtl/burst_writer_pkg.sv
// Shared types and sizing helpers for the burst writer and its gap timer.
package burst_writer_pkg;

  typedef enum logic [1:0] {
    START = 2'd0,
    WAIT  = 2'd1,
    REQ   = 2'd2
  } state_t;

  // Width needed to hold values 0..n inclusive.
  function automatic int count_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int DEFAULT_BEAT_W = count_w(4);
  localparam int DEFAULT_GAP_W  = count_w(5);

endpackage

// File: rtl/burst_writer_gap_timer.sv
// Enable-gated up-counter with synchronous clear; done flags the final gap cycle.
module gap_timer
  import burst_writer_pkg::*;
#(
  parameter int MAX = 5
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam int W = count_w(MAX);

  logic [W-1:0] count;

  always_ff @(posedge i_clk) begin
    if (i_reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + W'(1);
    end
  end

  assign done = (count == W'(MAX - 1));

endmodule

// File: rtl/burst_writer.sv
// Bus writer: waits a programmable gap, requests the shared bus, then drives
// BURST_LEN words, one per granted cycle, stalling while the arbiter is busy.
module burst_writer
  import burst_writer_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int COUNTER_MAX = 5,
  parameter int BURST_LEN   = 4,
  parameter int STEP        = 1,
  parameter int SEED        = 0
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_enable,
  input  logic              i_busy,
  output logic              o_req,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_last,
  output logic [15:0]       o_bursts,
  output state_t            o_state
);

  localparam int                BEAT_W    = count_w(BURST_LEN);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);

  state_t            state;
  state_t            state_next;
  logic [BEAT_W-1:0] beat;
  logic [DATA_W-1:0] data_reg;
  logic              gap_done;
  logic              grant;
  logic              last_beat;

  gap_timer #(
    .MAX (COUNTER_MAX)
  ) u_gap_timer (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .clear   (state == START),
    .enable  ((state == WAIT) && i_enable),
    .done    (gap_done)
  );

  // o_req is a real flop tracking entry into / exit from REQ.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= START;
      o_req <= 1'b0;
    end else begin
      state <= state_next;
      o_req <= (state_next == REQ);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      START: if (i_enable) state_next = WAIT;
      WAIT:  if (i_enable && gap_done) state_next = REQ;
      REQ:   if (last_beat) state_next = START;
      default: state_next = START;
    endcase
  end

  always_comb begin
    grant     = o_req && !i_busy;
    last_beat = grant && (beat == LAST_BEAT);
    o_valid   = grant;
    o_last    = last_beat;
  end

  assign o_data  = grant ? data_reg : {DATA_W{1'bz}};
  assign o_state = state;

  // Data keeps running across bursts; only reset returns it to SEED.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      data_reg <= DATA_W'(SEED);
      beat     <= '0;
      o_bursts <= '0;
    end else if (state == START) begin
      beat <= '0;
    end else if (grant) begin
      data_reg <= data_reg + DATA_W'(STEP);
      beat     <= last_beat ? '0 : beat + BEAT_W'(1);
      if (last_beat) o_bursts <= o_bursts + 16'd1;
    end
  end

endmodule

// File: tb/tb_burst_writer.sv
// Directed bench for burst_writer: three configurations, beat scoreboards
// popped by per-instance monitors, plus timing checks in the stimulus thread.
module tb_burst_writer;
  import burst_writer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic rst, en, busy;
  logic rst_bc, en_bc;
  bit   mon_on  = 1'b0;
  bit   mon_bc  = 1'b0;
  bit   bc_done = 1'b0;

  logic        req_a, valid_a, last_a;
  wire  [7:0]  data_a;
  logic [15:0] bursts_a;
  state_t      st_a;

  logic        req_b, valid_b, last_b;
  wire  [3:0]  data_b;
  logic [15:0] bursts_b;
  state_t      st_b;

  logic        req_c, valid_c, last_c;
  wire  [7:0]  data_c;
  logic [15:0] bursts_c;
  state_t      st_c;

  burst_writer dut_a (
    .i_clk(clk), .i_reset(rst), .i_enable(en), .i_busy(busy),
    .o_req(req_a), .o_data(data_a), .o_valid(valid_a), .o_last(last_a),
    .o_bursts(bursts_a), .o_state(st_a)
  );

  burst_writer #(.DATA_W(4), .STEP(3), .SEED(14)) dut_b (
    .i_clk(clk), .i_reset(rst_bc), .i_enable(en_bc), .i_busy(1'b0),
    .o_req(req_b), .o_data(data_b), .o_valid(valid_b), .o_last(last_b),
    .o_bursts(bursts_b), .o_state(st_b)
  );

  burst_writer #(.BURST_LEN(1), .COUNTER_MAX(1)) dut_c (
    .i_clk(clk), .i_reset(rst_bc), .i_enable(en_bc), .i_busy(1'b0),
    .o_req(req_c), .o_data(data_c), .o_valid(valid_c), .o_last(last_c),
    .o_bursts(bursts_c), .o_state(st_c)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard entries are {last, data}.
  logic [8:0] exp_a[$];
  logic [4:0] exp_b[$];
  logic [8:0] exp_c[$];

  task automatic push_a(input logic [7:0] d, input logic l);
    exp_a.push_back({l, d});
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int budget, output int edges);
    edges = 0;
    while (req_a !== 1'b1 && edges < budget) begin
      cyc();
      edges++;
    end
    chk("a_req_timeout", 32'(req_a), 32'd1);
  endtask

  logic [8:0] ea;
  always @(negedge clk) if (mon_on) begin
    if (valid_a === 1'b1) begin
      if (exp_a.size() == 0) chk("a_unexpected_beat", 32'(data_a), 32'hdead);
      else begin
        ea = exp_a.pop_front();
        chk("a_data", 32'(data_a), 32'(ea[7:0]));
        chk("a_last", 32'(last_a), 32'(ea[8]));
      end
    end else begin
      chk("a_idle_z", 32'(data_a === 8'hzz), 32'd1);
      chk("a_idle_last", 32'(last_a), 32'd0);
    end
  end

  logic [4:0] eb;
  always @(negedge clk) if (mon_bc) begin
    if (valid_b === 1'b1) begin
      if (exp_b.size() == 0) chk("b_unexpected_beat", 32'(data_b), 32'hdead);
      else begin
        eb = exp_b.pop_front();
        chk("b_data", 32'(data_b), 32'(eb[3:0]));
        chk("b_last", 32'(last_b), 32'(eb[4]));
      end
    end else begin
      chk("b_idle_z", 32'(data_b === 4'hz), 32'd1);
    end
  end

  logic [8:0] ec;
  int last_c_cyc = -1;
  always @(negedge clk) if (mon_bc) begin
    if (valid_c === 1'b1) begin
      if (last_c_cyc >= 0) chk("c_period", 32'(cyc_n - last_c_cyc), 32'd3);
      last_c_cyc = cyc_n;
      if (exp_c.size() == 0) chk("c_unexpected_beat", 32'(data_c), 32'hdead);
      else begin
        ec = exp_c.pop_front();
        chk("c_data", 32'(data_c), 32'(ec[7:0]));
        chk("c_last_eq_valid", 32'(last_c), 32'(ec[8]));
      end
    end else begin
      chk("c_idle_last", 32'(last_c), 32'd0);
    end
  end

  // Configurations b (narrow wrap) and c (single-word degenerate case).
  initial begin
    rst_bc = 1'b1;
    en_bc  = 1'b0;
    exp_b.push_back({1'b0, 4'd14});
    exp_b.push_back({1'b0, 4'd1});
    exp_b.push_back({1'b0, 4'd4});
    exp_b.push_back({1'b1, 4'd7});
    exp_b.push_back({1'b0, 4'd10});
    exp_b.push_back({1'b0, 4'd13});
    exp_b.push_back({1'b0, 4'd0});
    exp_b.push_back({1'b1, 4'd3});
    for (int i = 0; i < 7; i++) exp_c.push_back({1'b1, 8'(i)});
    cyc(2);
    mon_bc = 1'b1;
    rst_bc = 1'b0;
    en_bc  = 1'b1;
    cyc(20);
    en_bc = 1'b0;
    cyc(5);
    chk("b_bursts", 32'(bursts_b), 32'd2);
    chk("c_bursts", 32'(bursts_c), 32'd7);
    chk("b_idle_state", 32'(st_b), 32'(START));
    bc_done = 1'b1;
  end

  int e;
  initial begin
    rst  = 1'b1;
    en   = 1'b0;
    busy = 1'b0;
    cyc(2);
    mon_on = 1'b1;
    chk("rst_req", 32'(req_a), 32'd0);
    chk("rst_bursts", 32'(bursts_a), 32'd0);
    chk("rst_state", 32'(st_a), 32'(START));
    chk("rst_valid", 32'(valid_a), 32'd0);

    // Free-running: request after 6 edges, two bursts 0..3 and 4..7.
    en  = 1'b1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) push_a(8'(i), (i % 4) == 3);
    cyc(5);
    chk("t1_req_early", 32'(req_a), 32'd0);
    cyc(1);
    chk("t1_req_rise", 32'(req_a), 32'd1);
    cyc(4);
    chk("t1_req_fall", 32'(req_a), 32'd0);
    chk("t1_bursts_1", 32'(bursts_a), 32'd1);
    cyc(10);
    chk("t1_bursts_2", 32'(bursts_a), 32'd2);
    chk("t1_req_idle", 32'(req_a), 32'd0);

    // Busy for 3 cycles at request, then a 1-cycle stall after beat 1.
    busy = 1'b1;
    wait_req(20, e);
    chk("t2_req_latency", 32'(e), 32'd6);
    for (int i = 8; i < 12; i++) push_a(8'(i), i == 11);
    chk("t2_hold_0", 32'(req_a), 32'd1);
    cyc();
    chk("t2_hold_1", 32'(req_a), 32'd1);
    cyc();
    chk("t2_hold_2", 32'(req_a), 32'd1);
    cyc();
    busy = 1'b0;
    cyc();
    cyc();
    busy = 1'b1;
    chk("t2_hold_stall", 32'(req_a), 32'd1);
    cyc();
    busy = 1'b0;
    cyc();
    cyc();
    chk("t2_req_fall", 32'(req_a), 32'd0);
    chk("t2_bursts", 32'(bursts_a), 32'd3);

    // Enable dropped 4 cycles at gap=2 delays the request by exactly 4.
    cyc(3);
    en = 1'b0;
    cyc(4);
    chk("t4_wait_held", 32'(st_a), 32'(WAIT));
    chk("t4_req_low", 32'(req_a), 32'd0);
    en = 1'b1;
    cyc(2);
    chk("t4_req_not_yet", 32'(req_a), 32'd0);
    cyc(1);
    chk("t4_req_rise", 32'(req_a), 32'd1);
    en = 1'b0;
    for (int i = 12; i < 16; i++) push_a(8'(i), i == 15);
    cyc(4);
    chk("t4_burst_done", 32'(req_a), 32'd0);
    chk("t4_bursts", 32'(bursts_a), 32'd4);
    cyc(8);
    chk("t4_start_held", 32'(st_a), 32'(START));
    chk("t4_req_idle", 32'(req_a), 32'd0);

    // Reset mid-burst: partial burst dropped, data restarts at SEED.
    en = 1'b1;
    wait_req(20, e);
    chk("t5_req_latency", 32'(e), 32'd6);
    push_a(8'd16, 1'b0);
    push_a(8'd17, 1'b0);
    push_a(8'd18, 1'b0);
    cyc();
    cyc();
    rst = 1'b1;
    cyc();
    chk("t5_rst_req", 32'(req_a), 32'd0);
    chk("t5_rst_valid", 32'(valid_a), 32'd0);
    chk("t5_rst_bursts", 32'(bursts_a), 32'd0);
    chk("t5_rst_state", 32'(st_a), 32'(START));
    rst = 1'b0;
    for (int i = 0; i < 4; i++) push_a(8'(i), i == 3);
    wait_req(20, e);
    chk("t5_req_latency_2", 32'(e), 32'd6);
    cyc(4);
    chk("t5_req_fall", 32'(req_a), 32'd0);
    chk("t5_bursts", 32'(bursts_a), 32'd1);

    for (int i = 0; i < 200 && !bc_done; i++) cyc();
    chk("bc_timeout", 32'(bc_done), 32'd1);
    cyc(2);
    chk("a_queue_drained", 32'(exp_a.size()), 32'd0);
    chk("b_queue_drained", 32'(exp_b.size()), 32'd0);
    chk("c_queue_drained", 32'(exp_c.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
